// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared op codes, status-bit positions and FSM state
// encoding for the alu_seq block and its digit sub-module.
package alu_seq_pkg;

  // ALU op codes; codes 14 and 15 are undefined (pass A, update N/Z).
  typedef enum logic [3:0] {
    C_ALU_CTRL_THA = 4'd0,
    C_ALU_CTRL_BIT = 4'd1,
    C_ALU_CTRL_CMP = 4'd2,
    C_ALU_CTRL_INC = 4'd3,
    C_ALU_CTRL_DEC = 4'd4,
    C_ALU_CTRL_ASL = 4'd5,
    C_ALU_CTRL_LSR = 4'd6,
    C_ALU_CTRL_ROL = 4'd7,
    C_ALU_CTRL_ROR = 4'd8,
    C_ALU_CTRL_AND = 4'd9,
    C_ALU_CTRL_ORA = 4'd10,
    C_ALU_CTRL_EOR = 4'd11,
    C_ALU_CTRL_ADC = 4'd12,
    C_ALU_CTRL_SBC = 4'd13
  } alu_ctrl_e;

  // 6502 status layout: N V - B D I Z C
  localparam int C_FLAG_SHFT_C = 0;
  localparam int C_FLAG_SHFT_Z = 1;
  localparam int C_FLAG_SHFT_I = 2;
  localparam int C_FLAG_SHFT_D = 3;
  localparam int C_FLAG_SHFT_B = 4;
  localparam int C_FLAG_SHFT_U = 5;
  localparam int C_FLAG_SHFT_V = 6;
  localparam int C_FLAG_SHFT_N = 7;

  typedef enum logic [1:0] {
    C_ALU_ST_IDLE = 2'd0,
    C_ALU_ST_BUSY = 2'd1,
    C_ALU_ST_HOLD = 2'd2
  } alu_st_e;

endpackage

// File: rtl/alu_seq_bcd_digit.sv
// alu_seq_bcd_digit: one BCD digit of a 6502-style decimal add/subtract.
//   sub   : 0 = add (cin/cout are carry), 1 = subtract (cin/cout are borrow)
//   a, b  : operand nibbles (values >9 accepted, rule below defines result)
//   digit : result nibble, cout : carry/borrow to the next digit
module alu_seq_bcd_digit (
  input  logic       sub,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] digit,
  output logic       cout
);

  logic [4:0] s, s_adj;
  logic [5:0] d, d_adj;   // 2's complement, bit 5 is the sign

  always_comb begin
    s     = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    s_adj = s + 5'd6;
    d     = {2'b0, a} - {2'b0, b} - {5'b0, cin};
    d_adj = d - 6'd6;
    digit = s[3:0];
    cout  = 1'b0;
    if (sub) begin
      digit = d[3:0];
      if (d[5]) begin
        digit = d_adj[3:0];
        cout  = 1'b1;
      end
    end else if (s > 5'd9) begin
      digit = s_adj[3:0];
      cout  = 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit 6502-style ALU. Binary ops produce a result
// one edge after accept; decimal ADC/SBC walk one BCD digit per cycle.
//   CLK/RST               clock, async active-high reset
//   IN_VALID/IN_READY     op handshake (A, B, FLAG_IN, CTRL sampled on accept)
//   OUT_VALID/OUT_READY   result handshake (OUT, FLAG_OUT registered)
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit DEC_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [7:0]       FLAG_IN,
  input  logic [3:0]       CTRL,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT,
  output logic [7:0]       FLAG_OUT
);

  localparam int NDIG = WIDTH / 4;
  localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  alu_st_e          state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_nxt;
  logic [3:0]       ctrl_q;
  logic [7:0]       flag_q;
  logic [KW-1:0]    k_q;
  logic             cy_q;

  logic busy, accept, dec_sel, last;
  assign busy      = (state == C_ALU_ST_BUSY);
  assign IN_READY  = ~RST & ((state == C_ALU_ST_IDLE) | ((state == C_ALU_ST_HOLD) & OUT_READY));
  assign accept    = IN_VALID & IN_READY;
  assign OUT_VALID = (state == C_ALU_ST_HOLD);
  assign dec_sel   = DEC_EN & FLAG_IN[C_FLAG_SHFT_D] &
                     ((CTRL == C_ALU_CTRL_ADC) | (CTRL == C_ALU_CTRL_SBC));
  assign last      = (k_q == KW'(NDIG - 1));

  // Binary ALU. Live inputs drive it on accept; in BUSY the captured
  // operands drive it so its ADC/SBC V flag serves the decimal result.
  logic [WIDTH-1:0] op_a, op_b, res;
  logic [3:0]       op_c;
  logic [7:0]       op_f, fl;
  logic [WIDTH:0]   sum, dif, cmp;
  logic             nz;

  assign op_a = busy ? a_q    : A;
  assign op_b = busy ? b_q    : B;
  assign op_c = busy ? ctrl_q : CTRL;
  assign op_f = busy ? flag_q : FLAG_IN;

  always_comb begin
    res = op_a;
    fl  = op_f;
    nz  = 1'b0;
    sum = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_f[C_FLAG_SHFT_C]};
    // A + ~B + C: carry out is the 6502 "no borrow" C
    dif = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, op_f[C_FLAG_SHFT_C]};
    cmp = {1'b0, op_a} - {1'b0, op_b};
    case (op_c)
      C_ALU_CTRL_THA: ;
      C_ALU_CTRL_BIT: begin
        fl[C_FLAG_SHFT_N] = op_b[WIDTH-1];
        fl[C_FLAG_SHFT_V] = op_b[WIDTH-2];
        fl[C_FLAG_SHFT_Z] = ((op_a & op_b) == '0);
      end
      C_ALU_CTRL_CMP: begin
        fl[C_FLAG_SHFT_C] = ~cmp[WIDTH];
        fl[C_FLAG_SHFT_N] = cmp[WIDTH-1];
        fl[C_FLAG_SHFT_Z] = (cmp[WIDTH-1:0] == '0);
      end
      C_ALU_CTRL_INC: begin res = op_a + WIDTH'(1); nz = 1'b1; end
      C_ALU_CTRL_DEC: begin res = op_a - WIDTH'(1); nz = 1'b1; end
      C_ALU_CTRL_ASL: begin
        res = op_a << 1; fl[C_FLAG_SHFT_C] = op_a[WIDTH-1]; nz = 1'b1;
      end
      C_ALU_CTRL_LSR: begin
        res = op_a >> 1; fl[C_FLAG_SHFT_C] = op_a[0]; nz = 1'b1;
      end
      C_ALU_CTRL_ROL: begin
        res = {op_a[WIDTH-2:0], op_f[C_FLAG_SHFT_C]}; fl[C_FLAG_SHFT_C] = op_a[WIDTH-1]; nz = 1'b1;
      end
      C_ALU_CTRL_ROR: begin
        res = {op_f[C_FLAG_SHFT_C], op_a[WIDTH-1:1]}; fl[C_FLAG_SHFT_C] = op_a[0]; nz = 1'b1;
      end
      C_ALU_CTRL_AND: begin res = op_a & op_b; nz = 1'b1; end
      C_ALU_CTRL_ORA: begin res = op_a | op_b; nz = 1'b1; end
      C_ALU_CTRL_EOR: begin res = op_a ^ op_b; nz = 1'b1; end
      C_ALU_CTRL_ADC: begin
        res = sum[WIDTH-1:0];
        fl[C_FLAG_SHFT_C] = sum[WIDTH];
        fl[C_FLAG_SHFT_V] = (op_a[WIDTH-1] == op_b[WIDTH-1]) & (res[WIDTH-1] != op_a[WIDTH-1]);
        nz = 1'b1;
      end
      C_ALU_CTRL_SBC: begin
        res = dif[WIDTH-1:0];
        fl[C_FLAG_SHFT_C] = dif[WIDTH];
        fl[C_FLAG_SHFT_V] = (op_a[WIDTH-1] != op_b[WIDTH-1]) & (res[WIDTH-1] != op_a[WIDTH-1]);
        nz = 1'b1;
      end
      default: nz = 1'b1;
    endcase
    if (nz) begin
      fl[C_FLAG_SHFT_N] = res[WIDTH-1];
      fl[C_FLAG_SHFT_Z] = (res == '0);
    end
  end

  // Decimal digit step: single digit unit, nibble k of the captured operands.
  logic       dsub, dig_co;
  logic [3:0] dig;
  logic [7:0] dec_fl;
  assign dsub = (ctrl_q == C_ALU_CTRL_SBC);

  alu_seq_bcd_digit u_digit (
    .sub   (dsub),
    .a     (a_q[4*k_q +: 4]),
    .b     (b_q[4*k_q +: 4]),
    .cin   (cy_q),
    .digit (dig),
    .cout  (dig_co)
  );

  always_comb begin
    acc_nxt = acc_q;
    acc_nxt[4*k_q +: 4] = dig;
    dec_fl = flag_q;
    dec_fl[C_FLAG_SHFT_C] = dsub ? ~dig_co : dig_co;
    dec_fl[C_FLAG_SHFT_N] = acc_nxt[WIDTH-1];
    dec_fl[C_FLAG_SHFT_Z] = (acc_nxt == '0);
    dec_fl[C_FLAG_SHFT_V] = fl[C_FLAG_SHFT_V];
  end

  // FSM
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= C_ALU_ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      C_ALU_ST_IDLE: if (accept) state_nxt = dec_sel ? C_ALU_ST_BUSY : C_ALU_ST_HOLD;
      C_ALU_ST_BUSY: if (last)   state_nxt = C_ALU_ST_HOLD;
      C_ALU_ST_HOLD: begin
        if (accept)         state_nxt = dec_sel ? C_ALU_ST_BUSY : C_ALU_ST_HOLD;
        else if (OUT_READY) state_nxt = C_ALU_ST_IDLE;
      end
      default: state_nxt = C_ALU_ST_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_q <= '0; b_q <= '0; acc_q <= '0; ctrl_q <= '0; flag_q <= '0;
      k_q <= '0; cy_q <= 1'b0; OUT <= '0; FLAG_OUT <= '0;
    end else if (accept) begin
      a_q    <= A;
      b_q    <= B;
      ctrl_q <= CTRL;
      flag_q <= FLAG_IN;
      k_q    <= '0;
      cy_q   <= (CTRL == C_ALU_CTRL_SBC) ? ~FLAG_IN[C_FLAG_SHFT_C] : FLAG_IN[C_FLAG_SHFT_C];
      if (!dec_sel) begin
        OUT      <= res;
        FLAG_OUT <= fl;
      end
    end else if (busy) begin
      acc_q <= acc_nxt;
      cy_q  <= dig_co;
      k_q   <= k_q + KW'(1);
      if (last) begin
        OUT      <= acc_nxt;
        FLAG_OUT <= dec_fl;
      end
    end
  end

endmodule
